soc_glip_rx_packetizer: RTL and testbench

//   Sits directly downstream of the GLIP TCP bridge's fifo_in channel, in the clk_logic domain.

---
 rtl/soc_glip_rx_packetizer.sv | 209 ++++++++++++++++++++
 tb/tb_soc_glip_rx_packetizer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_glip_rx_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : soc_glip_rx_packetizer                                       |
// | Description : Frames the raw GLIP word stream (length word N followed by   |
// |               N payload words) into debug packets. Payload words pass      |
// |               through a DEPTH-entry FIFO with registered outputs. The      |
// |               final word of each packet is flagged with out_last, and      |
// |               delivered packets are counted in pkt_cnt.                    |
// | Optional    : SOC_GLIP_PKT_LEN_CHECK_EN - packets longer than MAX_LEN are  |
// |               drained (never forwarded) and err_drop pulses for one cycle. |
// | Ports       : clk_logic, rst (sync, active-high)                           |
// |               in_data/in_valid/in_ready    - GLIP word input handshake     |
// |               out_data/out_last/out_valid/out_ready - payload output       |
// |               pkt_cnt  - packets fully delivered (wraps)                   |
// |               err_drop - one-cycle pulse on a discarded packet             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module soc_glip_rx_packetizer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int MAX_LEN = 8
) (
    input  logic             clk_logic,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      pkt_cnt,
    output logic             err_drop
);

    localparam int               C_ADDR_W = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    remaining_q, remaining_d;
    logic [C_ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [C_ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH:0]      mem_q [DEPTH];          // {data, last}
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;

    logic                in_xfer;
    logic                out_xfer;
    logic                push;
    logic                push_last;
    logic                empty_d;
    logic                full_d;

`ifdef SOC_GLIP_PKT_LEN_CHECK_EN
    localparam logic [WIDTH-1:0] C_MAX_LEN = WIDTH'(MAX_LEN);
    logic err_drop_q, err_drop_d;
`else
    logic unused_max_len;
    assign unused_max_len = ^MAX_LEN;
`endif

    // in_ready is registered, so it never depends on out_ready in the same
    // cycle; a full FIFO keeps it low even if a pop happens this cycle.
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid_q & out_ready;
    assign push_last = (remaining_q == C_ONE);

    // ------------------------------------------------------------------
    // Framing state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        push        = 1'b0;
`ifdef SOC_GLIP_PKT_LEN_CHECK_EN
        err_drop_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_xfer) begin
                    remaining_d = in_data;
`ifdef SOC_GLIP_PKT_LEN_CHECK_EN
                    if (in_data > C_MAX_LEN) begin
                        state_d    = S_DRAIN;
                        err_drop_d = 1'b1;
                    end else if (in_data != '0) begin
                        state_d = S_PAYLOAD;
                    end
`else
                    if (in_data != '0) begin
                        state_d = S_PAYLOAD;
                    end
`endif
                end
            end
            S_PAYLOAD: begin
                if (in_xfer) begin
                    push        = 1'b1;
                    remaining_d = remaining_q - C_ONE;
                    if (push_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (in_xfer) begin
                    remaining_d = remaining_q - C_ONE;
                    if (push_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, registered head-of-queue and ready
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{C_ADDR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{C_ADDR_W{1'b0}}, out_xfer};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[C_ADDR_W] != rd_ptr_d[C_ADDR_W]) &&
                   (wr_ptr_d[C_ADDR_W-1:0] == rd_ptr_d[C_ADDR_W-1:0]);

        // The output register mirrors the entry the read pointer will point
        // at. When that entry is the one being written this cycle it is not
        // in memory yet, so take it straight from the input.
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
        if (!empty_d) begin
            out_valid_d = 1'b1;
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                out_data_d = in_data;
                out_last_d = push_last;
            end else begin
                {out_data_d, out_last_d} = mem_q[rd_ptr_d[C_ADDR_W-1:0]];
            end
        end

        in_ready_d = (state_d == S_PAYLOAD) ? !full_d : 1'b1;
        pkt_cnt_d  = pkt_cnt_q + {15'd0, out_xfer & out_last_q};
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clk_logic) begin
        if (push) begin
            mem_q[wr_ptr_q[C_ADDR_W-1:0]] <= {in_data, push_last};
        end
    end

    always_ff @(posedge clk_logic) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

`ifdef SOC_GLIP_PKT_LEN_CHECK_EN
    always_ff @(posedge clk_logic) begin
        if (rst) begin
            err_drop_q <= 1'b0;
        end else begin
            err_drop_q <= err_drop_d;
        end
    end
    assign err_drop = err_drop_q;
`else
    assign err_drop = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_glip_rx_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_soc_glip_rx_packetizer                                    |
// | Description : Directed self-checking bench for soc_glip_rx_packetizer      |
// |               (WIDTH=16, DEPTH=4, MAX_LEN=8).                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_soc_glip_rx_packetizer;

    logic        clk_logic;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pkt_cnt;
    logic        err_drop;

    int          total;
    int          bad;
    int          err_cnt;
    logic [16:0] obs_q [$];   // {data, last} of every output transfer

    soc_glip_rx_packetizer #(
        .WIDTH   (16),
        .DEPTH   (4),
        .MAX_LEN (8)
    ) u_dut (
        .clk_logic (clk_logic),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_cnt   (pkt_cnt),
        .err_drop  (err_drop)
    );

    initial clk_logic = 1'b0;
    always #5 clk_logic = ~clk_logic;

    always @(posedge clk_logic) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({out_data, out_last});
        end
        if (!rst && err_drop) begin
            err_cnt = err_cnt + 1;
        end
    end

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk_logic);
        #1;
        rst = 1'b0;
        obs_q.delete();
        err_cnt = 0;
    endtask

    task automatic send_word(input logic [15:0] w);
        bit ok;
        ok       = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk_logic);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: word %h not accepted, required acceptance", w);
        end
    endtask

    task automatic wait_out(input int n);
        int cyc;
        cyc = 0;
        while (obs_q.size() < n && cyc < 300) begin
            @(posedge clk_logic);
            #1;
            cyc++;
        end
        if (obs_q.size() < n) begin
            total++; bad++;
            $display("FAIL wait_out_timeout: got %0d words, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'hFFFF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk_logic);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        total++;
        if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        total++;
        if (pkt_cnt !== 16'h0000) begin bad++; $display("FAIL reset_pkt_cnt: got %h want 0000", pkt_cnt); end
        total++;
        if (err_drop !== 1'b0) begin bad++; $display("FAIL reset_err_drop: got %b want 0", err_drop); end
        rst = 1'b0;
    endtask

    // Scenario 1: 0x0003,A,B,C with out_ready=1
    task automatic test_basic();
        logic [16:0] exp [3];
        exp[0] = {16'h00A1, 1'b0};
        exp[1] = {16'h00B2, 1'b0};
        exp[2] = {16'h00C3, 1'b1};
        apply_reset();
        out_ready = 1'b1;
        send_word(16'h0003);
        send_word(16'h00A1);
        send_word(16'h00B2);
        send_word(16'h00C3);
        wait_out(3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_q.size() <= i || obs_q[i] !== exp[i]) begin
                bad++;
                $display("FAIL basic_word%0d: got %h want %h", i,
                         (obs_q.size() > i) ? obs_q[i] : 17'h0, exp[i]);
            end
        end
        total++;
        if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL basic_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    // Scenario 2: zero-length packet, then 0x0001,D
    task automatic test_zero_len();
        apply_reset();
        out_ready = 1'b1;
        send_word(16'h0000);
        repeat (3) @(posedge clk_logic);
        #1;
        total++;
        if (out_valid !== 1'b0 || obs_q.size() != 0) begin
            bad++; $display("FAIL zero_len_no_output: got valid=%b words=%0d want 0/0", out_valid, obs_q.size());
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_len_idle_ready: got %b want 1", in_ready); end
        total++;
        if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL zero_len_pkt_cnt0: got %0d want 0", pkt_cnt); end
        send_word(16'h0001);
        send_word(16'h00D4);
        wait_out(1);
        repeat (3) @(posedge clk_logic);
        #1;
        total++;
        if (obs_q.size() != 1 || obs_q[0] !== {16'h00D4, 1'b1}) begin
            bad++; $display("FAIL zero_len_D: got %0d words first=%h want 1 word 01a9",
                            obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'h0);
        end
        total++;
        if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL zero_len_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    // Scenario 3: 6-word packet against a stalled output, FIFO depth 4
    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        send_word(16'h0006);
        for (int i = 0; i < 4; i++) send_word(16'h1000 + 16'(i));
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'h1000 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall_cyc%0d: got v=%b d=%h l=%b rdy=%b want v=1 d=1000 l=0 rdy=0",
                         c, out_valid, out_data, out_last, in_ready);
            end
            @(posedge clk_logic);
            #1;
        end
        out_ready = 1'b1;
        send_word(16'h1004);
        send_word(16'h1005);
        wait_out(6);
        repeat (3) @(posedge clk_logic);
        #1;
        total++;
        if (obs_q.size() != 6) begin bad++; $display("FAIL bp_count: got %0d want 6", obs_q.size()); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (obs_q.size() <= i || obs_q[i] !== {16'h1000 + 16'(i), (i == 5)}) begin
                bad++;
                $display("FAIL bp_word%0d: got %h want %h", i,
                         (obs_q.size() > i) ? obs_q[i] : 17'h0, {16'h1000 + 16'(i), (i == 5)});
            end
        end
        total++;
        if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL bp_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    // Scenario 4: back-to-back packets with random out_ready
    task automatic test_back_to_back();
        logic [16:0] exp [3];
        exp[0] = {16'h00E5, 1'b0};
        exp[1] = {16'h00F6, 1'b1};
        exp[2] = {16'h0077, 1'b1};
        apply_reset();
        fork
            begin
                send_word(16'h0002);
                send_word(16'h00E5);
                send_word(16'h00F6);
                send_word(16'h0001);
                send_word(16'h0077);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk_logic);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_out(3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_q.size() <= i || obs_q[i] !== exp[i]) begin
                bad++;
                $display("FAIL b2b_word%0d: got %h want %h", i,
                         (obs_q.size() > i) ? obs_q[i] : 17'h0, exp[i]);
            end
        end
        total++;
        if (pkt_cnt !== 16'd2) begin bad++; $display("FAIL b2b_pkt_cnt: got %0d want 2", pkt_cnt); end
    endtask

    // Scenario 5: reset in the middle of a packet
    task automatic test_reset_midpacket();
        apply_reset();
        out_ready = 1'b0;
        send_word(16'h0005);
        send_word(16'h2001);
        send_word(16'h2002);
        rst = 1'b1;
        @(posedge clk_logic);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_last !== 1'b0 || in_ready !== 1'b0 || pkt_cnt !== 16'h0) begin
            bad++;
            $display("FAIL midrst_outputs: got v=%b d=%h l=%b rdy=%b cnt=%h want 0/0000/0/0/0000",
                     out_valid, out_data, out_last, in_ready, pkt_cnt);
        end
        rst = 1'b0;
        obs_q.delete();
        err_cnt   = 0;
        out_ready = 1'b1;
        send_word(16'h0001);
        send_word(16'h0088);
        wait_out(1);
        repeat (4) @(posedge clk_logic);
        #1;
        total++;
        if (obs_q.size() != 1 || obs_q[0] !== {16'h0088, 1'b1}) begin
            bad++; $display("FAIL midrst_H: got %0d words first=%h want 1 word 00111",
                            obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'h0);
        end
        total++;
        if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL midrst_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    // Scenario 6: 9-word packet against MAX_LEN=8, then 0x0001,J
    task automatic test_len_check();
        apply_reset();
        out_ready = 1'b1;
        send_word(16'h0009);
        for (int i = 0; i < 9; i++) send_word(16'h3000 + 16'(i));
        send_word(16'h0001);
        send_word(16'h0099);
`ifdef SOC_GLIP_PKT_LEN_CHECK_EN
        wait_out(1);
        repeat (5) @(posedge clk_logic);
        #1;
        total++;
        if (err_cnt != 1) begin bad++; $display("FAIL len_err_pulses: got %0d want 1", err_cnt); end
        total++;
        if (obs_q.size() != 1 || obs_q[0] !== {16'h0099, 1'b1}) begin
            bad++; $display("FAIL len_only_J: got %0d words first=%h want 1 word 00133",
                            obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'h0);
        end
        total++;
        if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL len_pkt_cnt: got %0d want 1", pkt_cnt); end
`else
        wait_out(10);
        repeat (5) @(posedge clk_logic);
        #1;
        total++;
        if (err_cnt != 0) begin bad++; $display("FAIL len_err_pulses: got %0d want 0", err_cnt); end
        total++;
        if (obs_q.size() != 10) begin bad++; $display("FAIL len_count: got %0d want 10", obs_q.size()); end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (obs_q.size() <= i || obs_q[i] !== {16'h3000 + 16'(i), (i == 8)}) begin
                bad++;
                $display("FAIL len_word%0d: got %h want %h", i,
                         (obs_q.size() > i) ? obs_q[i] : 17'h0, {16'h3000 + 16'(i), (i == 8)});
            end
        end
        total++;
        if (obs_q.size() < 10 || obs_q[9] !== {16'h0099, 1'b1}) begin
            bad++; $display("FAIL len_J: got %h want 00133", (obs_q.size() > 9) ? obs_q[9] : 17'h0);
        end
        total++;
        if (pkt_cnt !== 16'd2) begin bad++; $display("FAIL len_pkt_cnt: got %0d want 2", pkt_cnt); end
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_back_to_back();
        test_reset_midpacket();
        test_len_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
